// File: rtl/host_csr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : host_csr_pkg                                                  |
// | Description : Shared types and helpers for the host CSR channel arbiter.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package host_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [11:0] c_tohost_addr = 12'h780;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Owner values 0..NREQ-1 are clients, NREQ is the tohost poller.
    function automatic int owner_w(input int nreq);
        return idx_w(nreq + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_csr_arbiter_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                    |
// | Description : One-hot grant to the first request at or after ptr (mod NREQ).|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module rr_arbiter
    import host_csr_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [idx_w(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]         grant
);

    localparam int c_ptr_w = idx_w(NREQ);

    logic [c_ptr_w-1:0] w_idx;
    logic               w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k >= NREQ) ? c_ptr_w'(int'(ptr) + k - NREQ)
                                            : c_ptr_w'(int'(ptr) + k);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/host_csr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : host_csr_arbiter                                              |
// | Description : Shares the host CSR channel between NREQ clients and a        |
// |               tohost poller; one transaction in flight at a time.           |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module host_csr_arbiter
    import host_csr_pkg::*;
#(
    parameter int                NREQ          = 2,
    parameter int                ADDR_W        = 12,
    parameter int                DATA_W        = 64,
    parameter int                POLL_INTERVAL = 16,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR   = ADDR_W'(c_tohost_addr),
    parameter int                TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          cli_req_valid,
    output logic [NREQ-1:0]          cli_req_ready,
    input  logic [NREQ-1:0]          cli_req_rw,
    input  logic [NREQ*ADDR_W-1:0]   cli_req_addr,
    input  logic [NREQ*DATA_W-1:0]   cli_req_data,
    output logic [NREQ-1:0]          cli_rep_valid,
    output logic [DATA_W-1:0]        cli_rep_data,
    output logic                     host_req_valid,
    input  logic                     host_req_ready,
    output logic                     host_req_rw,
    output logic [ADDR_W-1:0]        host_req_addr,
    output logic [DATA_W-1:0]        host_req_data,
    input  logic                     host_rep_valid,
    input  logic [DATA_W-1:0]        host_rep_bits,
    output logic                     host_rep_ready,
    output logic                     exit_valid,
    output logic [30:0]              exit_code,
    output logic                     timeout_err
);

    localparam int c_ptr_w  = idx_w(NREQ);
    localparam int c_own_w  = owner_w(NREQ);
    localparam int c_pcnt_w = idx_w(POLL_INTERVAL);
    localparam int c_wcnt_w = idx_w(TIMEOUT);

    localparam logic [c_own_w-1:0]  c_owner_poll = c_own_w'(NREQ);
    localparam logic [c_ptr_w-1:0]  c_cli_last   = c_ptr_w'(NREQ - 1);
    localparam logic [c_pcnt_w-1:0] c_poll_last  = c_pcnt_w'(POLL_INTERVAL - 1);
    localparam logic [c_wcnt_w-1:0] c_wait_last  = c_wcnt_w'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_pcnt_w-1:0] r_poll_cnt;
    logic [c_wcnt_w-1:0] r_wait_cnt;
    logic [c_own_w-1:0]  r_owner;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [NREQ-1:0]     r_rep_valid;
    logic [DATA_W-1:0]   r_rep_data;
    logic                r_exit_valid;
    logic [30:0]         r_exit_code;
    logic                r_timeout_err;

    logic [NREQ-1:0]     w_grant;
    logic [c_ptr_w-1:0]  w_grant_idx;
    logic [c_ptr_w-1:0]  w_owner_idx;
    logic [c_ptr_w-1:0]  w_ptr_next;
    logic                w_owner_is_poll;
    logic                w_poll_due;
    logic                w_take_cli;
    logic                w_take_poll;
    logic                w_rep_done;
    logic                w_timeout;

    logic [ADDR_W-1:0]   w_cli_addr [NREQ];
    logic [DATA_W-1:0]   w_cli_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_cli_addr[g] = cli_req_addr[g*ADDR_W +: ADDR_W];
        assign w_cli_data[g] = cli_req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (cli_req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_grant_idx = c_ptr_w'(k);
            end
        end
    end

    assign w_owner_idx     = r_owner[c_ptr_w-1:0];
    assign w_owner_is_poll = (r_owner == c_owner_poll);
    assign w_ptr_next      = (w_owner_idx == c_cli_last) ? '0 : w_owner_idx + 1'b1;
    assign w_poll_due      = (r_poll_cnt == c_poll_last) && !r_exit_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs are forced low while reset is held so that nothing is
    // accepted or acknowledged during reset.
    always_comb begin
        w_next_state   = r_state;
        cli_req_ready  = '0;
        host_req_valid = 1'b0;
        host_rep_ready = 1'b0;
        w_take_cli     = 1'b0;
        w_take_poll    = 1'b0;
        w_rep_done     = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|cli_req_valid) begin
                    cli_req_ready = w_grant;
                    w_take_cli    = 1'b1;
                    w_next_state  = ST_ISSUE;
                end else if (w_poll_due) begin
                    w_take_poll  = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                host_req_valid = 1'b1;
                if (host_req_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                host_rep_ready = 1'b1;
                if (host_rep_valid) begin
                    w_rep_done   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (!reset) begin
            cli_req_ready  = '0;
            host_req_valid = 1'b0;
            host_rep_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_poll_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_owner       <= '0;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_rep_valid   <= '0;
            r_rep_data    <= '0;
            r_exit_valid  <= 1'b0;
            r_exit_code   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rep_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    // A client beats a due poll; the counter then holds at its
                    // terminal value so the poll fires on the next free cycle.
                    if (w_take_cli) begin
                        r_owner <= c_own_w'(w_grant_idx);
                        r_rw    <= cli_req_rw[w_grant_idx];
                        r_addr  <= w_cli_addr[w_grant_idx];
                        r_data  <= w_cli_data[w_grant_idx];
                    end else if (w_take_poll) begin
                        r_owner    <= c_owner_poll;
                        r_rw       <= 1'b0;
                        r_addr     <= TOHOST_ADDR;
                        r_data     <= '0;
                        r_poll_cnt <= '0;
                    end else if (r_poll_cnt != c_poll_last) begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_rep_done || w_timeout) begin
                        if (w_owner_is_poll) begin
                            if (w_rep_done && (host_rep_bits[31:0] != 32'd0)) begin
                                r_exit_valid <= 1'b1;
                                r_exit_code  <= host_rep_bits[31:1];
                            end
                        end else begin
                            r_rep_valid[w_owner_idx] <= 1'b1;
                            r_rep_data               <= w_rep_done ? host_rep_bits : '0;
                            r_rr_ptr                 <= w_ptr_next;
                        end
                        if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cli_rep_valid = r_rep_valid;
    assign cli_rep_data  = r_rep_data;
    assign host_req_rw   = r_rw;
    assign host_req_addr = r_addr;
    assign host_req_data = r_data;
    assign exit_valid    = r_exit_valid;
    assign exit_code     = r_exit_code;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire
